// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite palette RAM.
package sprite_pkg;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   localparam logic [11:0] DEF_SKY_RGB = 12'h6AF;

   typedef enum logic {INIT, IDLE} pal_state_e;

   // Bank-select width; a single-bank palette still gets a 1-bit select.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/palette_mem.sv
// Simple dual-port palette storage: one write port, one registered read port, read-first.
// Read data register resets to zero; array contents are loaded by the owner's init sweep.
module palette_mem #(
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [11:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [11:0]   rdata
);

   logic [11:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Same-edge write lands after this sample, so a colliding read sees the old entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sprite_palette_ram.sv
// Multi-bank sprite palette: {bank,idx} -> RGB444, 1-cycle registered lookup; writes stall (wr_ready=0) during init sweep.
// Optional PALETTE_FADE_EN adds a fade port that right-shifts each channel in the output stage.
module sprite_palette_ram
   import sprite_pkg::*;
#(
   parameter int          IDX_W     = 4,
   parameter int          NUM_BANKS = 8,
   parameter logic [11:0] DEF_RGB   = DEF_SKY_RGB,
   parameter int          KEY_IDX   = 1
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          rd_en,
   input  logic [sel_w(NUM_BANKS)-1:0]   rd_bank,
   input  logic [IDX_W-1:0]              rd_idx,
   output logic                          rd_valid,
   output logic [3:0]                    red,
   output logic [3:0]                    green,
   output logic [3:0]                    blue,
   output logic                          transp,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [sel_w(NUM_BANKS)-1:0]   wr_bank,
   input  logic [IDX_W-1:0]              wr_idx,
   input  logic [11:0]                   wr_rgb,
   output logic                          init_busy
`ifdef PALETTE_FADE_EN
   ,
   input  logic [1:0]                    fade
`endif
);

   localparam int DEPTH  = 2 ** IDX_W;
   localparam int BANK_W = sel_w(NUM_BANKS);
   localparam int AW     = BANK_W + IDX_W;
   localparam int TOTAL  = NUM_BANKS * DEPTH;

   pal_state_e    state, state_nxt;
   logic [AW-1:0] sweep_cnt;
   logic          sweep_last;

   logic          mem_we, mem_re;
   logic [AW-1:0] mem_waddr;
   logic [11:0]   mem_wdata, mem_rdata;
   logic          rd_fire, rd_in_range, wr_in_range;
   logic          oob_q;
   logic [1:0]    fade_q;
   rgb12_t        rgb_sel;

   assign sweep_last  = (sweep_cnt == AW'(TOTAL - 1));
   assign rd_in_range = (32'(rd_bank) < NUM_BANKS);
   assign wr_in_range = (32'(wr_bank) < NUM_BANKS);
   assign rd_fire     = rd_en && (state == IDLE);
   assign mem_re      = rd_fire && rd_in_range;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      init_busy = 1'b1;
      wr_ready  = 1'b0;
      case (state)
         INIT: if (sweep_last) state_nxt = IDLE;
         IDLE: begin
            init_busy = 1'b0;
            wr_ready  = 1'b1;
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)              sweep_cnt <= '0;
      else if (state == INIT) sweep_cnt <= sweep_cnt + 1'b1;
   end

   // Init sweep owns the write port; host writes to a missing bank are accepted but dropped.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = {wr_bank, wr_idx};
      mem_wdata = wr_rgb;
      if (state == INIT) begin
         mem_we    = 1'b1;
         mem_waddr = sweep_cnt;
         mem_wdata = DEF_RGB;
      end else begin
         mem_we    = wr_valid && wr_in_range;
      end
   end

   palette_mem #(
      .DEPTH (TOTAL),
      .AW    (AW)
   ) u_mem (
      .clk   (Clk),
      .rst   (Reset),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr ({rd_bank, rd_idx}),
      .rdata (mem_rdata)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rd_valid <= 1'b0;
         transp   <= 1'b0;
         oob_q    <= 1'b0;
         fade_q   <= 2'd0;
      end else begin
         rd_valid <= rd_fire;
         if (rd_fire) begin
            transp <= (rd_idx == IDX_W'(KEY_IDX));
            oob_q  <= !rd_in_range;
`ifdef PALETTE_FADE_EN
            fade_q <= fade;
`else
            fade_q <= 2'd0;
`endif
         end
      end
   end

   // Out-of-range lookups read as the default colour; the RAM holds its last value.
   assign rgb_sel = oob_q ? rgb12_t'(DEF_RGB) : rgb12_t'(mem_rdata);

   assign red   = rgb_sel.r >> fade_q;
   assign green = rgb_sel.g >> fade_q;
   assign blue  = rgb_sel.b >> fade_q;

endmodule
